// File: rtl/bcd_serial_subtractor.sv
// Digit-serial packed-BCD subtractor (A - B - bin), one digit per clock, LSD first.
// Define BCD_SUB_SIGN_MAG_EN to return sign/magnitude instead of ten's complement on a negative result.
module bcd_serial_subtractor #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                bin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] diff,
  output logic                bout,
  output logic                invalid,
  output logic                neg
);

  localparam int W = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef BCD_SUB_SIGN_MAG_EN
    COMP = 2'd2,
`endif
    RUN  = 2'd1,
    DONE = 2'd3
  } state_t;

  // One digit of x - y - bw: returns {borrow_out, bcd_digit}.
  function automatic logic [4:0] digit_sub(input logic [3:0] x, input logic [3:0] y, input logic bw);
    logic [4:0] t;
    t = {1'b0, x} - {1'b0, y} - {4'b0000, bw};
    if (t[4]) begin
      digit_sub = {1'b1, t[3:0] + 4'd10};
    end else begin
      digit_sub = {1'b0, t[3:0]};
    end
  endfunction

  state_t           state_r, state_next_s;
  logic [W-1:0]     a_sh_r, b_sh_r, res_r, res_next_s;
  logic [IDX_W-1:0] idx_r;
  logic             borrow_r, inv_acc_r;
  logic [4:0]       step_s;
  logic             last_s, inv_now_s, accept_s;

  assign step_s     = digit_sub(a_sh_r[3:0], b_sh_r[3:0], borrow_r);
  assign res_next_s = (res_r >> 3'd4) | (W'(step_s[3:0]) << (W - 4));
  assign last_s     = (idx_r == LAST_IDX);
  assign inv_now_s  = inv_acc_r | (a_sh_r[3:0] > 4'd9) | (b_sh_r[3:0] > 4'd9);
  assign accept_s   = start && ((state_r == IDLE) || (state_r == DONE));

`ifdef BCD_SUB_SIGN_MAG_EN
  logic to_comp_s;
  logic neg_r;
  assign to_comp_s = (state_r == RUN) && last_s && step_s[4] && !inv_now_s;
  assign neg       = neg_r;
`else
  assign neg = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (!last_s) begin
          state_next_s = RUN;
        end else begin
`ifdef BCD_SUB_SIGN_MAG_EN
          if (to_comp_s) state_next_s = COMP;
          else           state_next_s = DONE;
`else
          state_next_s = DONE;
`endif
        end
      end
`ifdef BCD_SUB_SIGN_MAG_EN
      COMP: begin
        if (last_s) state_next_s = DONE;
        else        state_next_s = COMP;
      end
`endif
      DONE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand shifters, borrow chain, digit counter and handshake flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      res_r     <= '0;
      idx_r     <= '0;
      borrow_r  <= 1'b0;
      inv_acc_r <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= (state_next_s == DONE);
`ifdef BCD_SUB_SIGN_MAG_EN
      busy <= (state_next_s == RUN) || (state_next_s == COMP);
`else
      busy <= (state_next_s == RUN);
`endif
      if (accept_s) begin
        a_sh_r    <= a;
        b_sh_r    <= b;
        borrow_r  <= bin;
        idx_r     <= '0;
        inv_acc_r <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      end else if (to_comp_s) begin
        // Negate the raw result serially: 0 - result.
        a_sh_r    <= '0;
        b_sh_r    <= res_next_s;
        borrow_r  <= 1'b0;
        idx_r     <= '0;
        inv_acc_r <= inv_now_s;
      end else if (state_r == COMP) begin
        a_sh_r   <= a_sh_r >> 3'd4;
        b_sh_r   <= b_sh_r >> 3'd4;
        borrow_r <= step_s[4];
        res_r    <= res_next_s;
        idx_r    <= idx_r + IDX_W'(1'b1);
`endif
      end else if (state_r == RUN) begin
        a_sh_r    <= a_sh_r >> 3'd4;
        b_sh_r    <= b_sh_r >> 3'd4;
        borrow_r  <= step_s[4];
        res_r     <= res_next_s;
        idx_r     <= idx_r + IDX_W'(1'b1);
        inv_acc_r <= inv_now_s;
      end
    end
  end

  // Result outputs, updated only on the edge entering DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff    <= '0;
      bout    <= 1'b0;
      invalid <= 1'b0;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_r   <= 1'b0;
`endif
    end else if ((state_r == RUN) && (state_next_s == DONE)) begin
      diff    <= res_next_s;
      bout    <= step_s[4];
      invalid <= inv_now_s;
`ifdef BCD_SUB_SIGN_MAG_EN
      neg_r   <= 1'b0;
    end else if ((state_r == COMP) && (state_next_s == DONE)) begin
      diff    <= res_next_s;
      bout    <= 1'b1;
      invalid <= 1'b0;
      neg_r   <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_bcd_serial_subtractor.sv
// Scoreboard bench for bcd_serial_subtractor (DIGITS=4); honours BCD_SUB_SIGN_MAG_EN if defined.
module tb_bcd_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst_n, start, bin;
  logic [15:0] a, b, diff;
  logic        busy, done, bout, invalid, neg;

  bcd_serial_subtractor #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout), .invalid(invalid), .neg(neg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] diff;
    logic        bout;
    logic        invalid;
    logic        neg;
    logic        chk_arith;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [15:0] d, input logic bo,
                              input logic inv, input logic ng, input logic ca);
    exp_t e;
    e.name = n; e.diff = d; e.bout = bo; e.invalid = inv; e.neg = ng; e.chk_arith = ca; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = q.pop_front();
        if (e.chk_arith) begin
          check({e.name, "_diff"}, diff, e.diff);
          check({e.name, "_bout"}, bout, e.bout);
        end
        check({e.name, "_invalid"}, invalid, e.invalid);
        check({e.name, "_neg"}, neg, e.neg);
        check({e.name, "_latency"}, cyc, e.cyc);
      end
    end
  end

  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ibin,
                       input logic push, input exp_t e, input int lat);
    exp_t ex;
    ex = e;
    a = ia; b = ib; bin = ibin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF; bin = 1'b1;
    if (push) begin
      ex.cyc = cyc + lat;
      q.push_back(ex);
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) return;
      check({name, "_busy"}, busy, 1'b1);
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a = 16'h0000; b = 16'h0000; bin = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_diff", diff, 16'h0000);
    check("rst_bout", bout, 1'b0);
    check("rst_invalid", invalid, 1'b0);
    check("rst_neg", neg, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(16'h5000, 16'h1234, 1'b0, 1'b1, mk("t5000_1234", 16'h3766, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t5000_1234");

`ifdef BCD_SUB_SIGN_MAG_EN
    issue(16'h0000, 16'h0001, 1'b0, 1'b1, mk("t0_1", 16'h0001, 1'b1, 1'b0, 1'b1, 1'b1), 8);
`else
    issue(16'h0000, 16'h0001, 1'b0, 1'b1, mk("t0_1", 16'h9999, 1'b1, 1'b0, 1'b0, 1'b1), 4);
`endif
    wait_done("t0_1");

    issue(16'h0100, 16'h0099, 1'b1, 1'b1, mk("t0100_0099", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t0100_0099");
    issue(16'h9999, 16'h0000, 1'b1, 1'b1, mk("t9999_0000", 16'h9998, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t9999_0000");

    issue(16'h00A3, 16'h0001, 1'b0, 1'b1, mk("t_invalid", 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0), 4);
    wait_done("t_invalid");
    issue(16'h0005, 16'h0002, 1'b0, 1'b1, mk("t0005_0002", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t0005_0002");

    // Second start while busy must be ignored.
    issue(16'h0500, 16'h0001, 1'b0, 1'b1, mk("t_ignore", 16'h0499, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    @(posedge clk);
    @(posedge clk);
    #1;
    a = 16'h9999; b = 16'h1111; bin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("t_ignore");

    // Asynchronous reset mid-operation.
    issue(16'h0777, 16'h0001, 1'b0, 1'b0, mk("t_abort", 16'h0776, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_diff", diff, 16'h0000);
    check("abort_bout", bout, 1'b0);
    check("abort_invalid", invalid, 1'b0);
    check("abort_neg", neg, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16'h0042, 16'h0017, 1'b0, 1'b1, mk("t_after_rst", 16'h0025, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t_after_rst");

    // Back-to-back: start asserted during DONE.
    issue(16'h0300, 16'h0100, 1'b0, 1'b1, mk("t_b2b_first", 16'h0200, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    wait_done("t_b2b_first");
    issue(16'h0010, 16'h0001, 1'b0, 1'b1, mk("t_b2b_second", 16'h0009, 1'b0, 1'b0, 1'b0, 1'b1), 4);
    check("b2b_diff_held", diff, 16'h0200);
    check("b2b_done_low", done, 1'b0);
    wait_done("t_b2b_second");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
